hvtx_sched: RTL and testbench

Period scheduler for the HDMI transmit path. It sits beside the timing generator, takes the same x/y raster position, and drives per-pixel period classification. The periods are control, video preamble/guard, and data-island preamble/guard/packet. It also round-robin arbitrates packet requesters (InfoFrame, audio, …) for the data-island slots in horizontal blanking. Outputs are pipeline-aligned with the sync/DE outputs of the timing generator, so the symbol mux consumes them directly.

---
 rtl/hvtx_pkg.sv | 24 ++
 rtl/hvtx_rr_arb.sv | 46 ++++
 rtl/hvtx_sched.sv | 207 ++++++++++++++++++++
 tb/tb_hvtx_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hvtx_pkg.sv
// Shared types and constants for the HDMI transmit period scheduler.
package hvtx_pkg;

    typedef enum logic [2:0] {
        PER_CTL    = 3'd0,
        PER_VPRE   = 3'd1,
        PER_VGUARD = 3'd2,
        PER_VIDEO  = 3'd3,
        PER_DPRE   = 3'd4,
        PER_DGUARD = 3'd5,
        PER_DATA   = 3'd6
    } period_t;

    localparam int unsigned PREAMBLE_LEN = 8;
    localparam int unsigned GUARD_LEN    = 2;
    localparam int unsigned PACKET_LEN   = 32;
    localparam int unsigned VPRE_OFFSET  = 10;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hvtx_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after the rotating
// priority pointer; the pointer moves past the winner when a grant is taken.
module hvtx_rr_arb import hvtx_pkg::*; #(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned IW    = idx_w(N_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_advance,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] j_idx;
    logic          found;

    // Search requesters starting at the pointer, wrapping around once.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        j_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j_idx = IW'((32'(ptr_q) + k) % N_REQ);
            if (!found && i_req[j_idx]) begin
                found        = 1'b1;
                o_idx        = j_idx;
                o_gnt[j_idx] = 1'b1;
            end
        end
        ptr_d = IW'((32'(o_idx) + 32'd1) % N_REQ);
    end

    // Pointer persists across lines and frames; only a taken grant moves it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else if (i_advance && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hvtx_sched.sv
// Per-pixel HDMI period classifier and data-island packet scheduler.
// Outputs lag i_x/i_y by two cycles to line up with the timing generator.
module hvtx_sched import hvtx_pkg::*; #(
    parameter  int unsigned WID           = 12,
    parameter  int unsigned FRAME_WIDTH   = 1650,
    parameter  int unsigned FRAME_HEIGHT  = 750,
    parameter  int unsigned ACTIVE_WIDTH  = 1280,
    parameter  int unsigned ACTIVE_HEIGHT = 720,
    parameter  int unsigned ISLAND_GAP    = 4,
    parameter  int unsigned N_REQ         = 2,
    parameter  int unsigned MAX_PKTS      = 2,
    localparam int unsigned SW            = idx_w(N_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WID-1:0]   i_x,
    input  logic [WID-1:0]   i_y,
    input  logic [N_REQ-1:0] i_req,
    output period_t          o_period,
    output logic [N_REQ-1:0] o_gnt,
    output logic [SW-1:0]    o_sel,
    output logic [4:0]       o_pkt_cnt
);

    localparam int unsigned IS = ACTIVE_WIDTH + ISLAND_GAP;

    if (IS + 12 + PACKET_LEN * MAX_PKTS + 12 > FRAME_WIDTH - VPRE_OFFSET) begin : g_bad_island
        $fatal(1, "hvtx_sched: data island overruns the video preamble");
    end
    if (MAX_PKTS < 1 || MAX_PKTS > 4) begin : g_bad_max
        $fatal(1, "hvtx_sched: MAX_PKTS must be 1..4");
    end

    localparam logic [WID-1:0] IS_X   = WID'(IS);
    localparam logic [WID-1:0] AW_X   = WID'(ACTIVE_WIDTH);
    localparam logic [WID-1:0] AH_Y   = WID'(ACTIVE_HEIGHT);
    localparam logic [WID-1:0] LAST_Y = WID'(FRAME_HEIGHT - 1);
    localparam logic [WID-1:0] VPRE_X = WID'(FRAME_WIDTH - VPRE_OFFSET);
    localparam logic [WID-1:0] VGRD_X = WID'(FRAME_WIDTH - GUARD_LEN);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DPRE   = 3'd1;
    localparam logic [2:0] ST_LGUARD = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_TGUARD = 3'd4;

    logic [2:0]       st_q, st_d, cur_st;
    logic [4:0]       cnt_q, cnt_d, cur_cnt;
    logic [2:0]       pkts_q, pkts_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic             advance;
    logic [N_REQ-1:0] arb_gnt;
    logic [SW-1:0]    arb_idx;
    logic [WID-1:0]   y_nxt;
    logic             next_active;
    period_t          raster_per;
    period_t          per_s;

    period_t          s1_per_q;
    logic [N_REQ-1:0] s1_gnt_q;
    logic [SW-1:0]    s1_sel_q;
    logic [4:0]       s1_cnt_q;

    hvtx_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .i_advance (advance),
        .o_gnt     (arb_gnt),
        .o_idx     (arb_idx)
    );

    // Raster-only classification: video area plus video preamble/guard
    // ahead of an active next line (last frame line wraps to line 0).
    always_comb begin
        y_nxt       = (i_y == LAST_Y) ? '0 : i_y + 1'b1;
        next_active = (y_nxt < AH_Y);
        if (i_x < AW_X && i_y < AH_Y) begin
            raster_per = PER_VIDEO;
        end else if (next_active && i_x >= VGRD_X) begin
            raster_per = PER_VGUARD;
        end else if (next_active && i_x >= VPRE_X) begin
            raster_per = PER_VPRE;
        end else begin
            raster_per = PER_CTL;
        end
    end

    // Island sequencing. The registered state describes the pixel now on
    // i_x, except that the IDLE->DPRE launch is resolved combinationally
    // so pixel IS itself is already preamble; decisions use i_req at the
    // decision pixel.
    always_comb begin
        cur_st  = st_q;
        cur_cnt = cnt_q;
        if (st_q == ST_IDLE) begin
            cur_cnt = '0;
            if (i_x == IS_X && |i_req) begin
                cur_st = ST_DPRE;
            end
        end
        st_d    = cur_st;
        cnt_d   = cur_cnt + 5'd1;
        pkts_d  = pkts_q;
        advance = 1'b0;
        case (cur_st)
            ST_DPRE: begin
                if (cur_cnt == 5'(PREAMBLE_LEN - 1)) begin
                    st_d  = ST_LGUARD;
                    cnt_d = '0;
                end
            end
            ST_LGUARD: begin
                if (cur_cnt == 5'(GUARD_LEN - 1)) begin
                    cnt_d = '0;
                    if (|i_req) begin
                        st_d    = ST_DATA;
                        advance = 1'b1;
                        pkts_d  = 3'd1;
                    end else begin
                        st_d = ST_TGUARD;
                    end
                end
            end
            ST_DATA: begin
                if (cur_cnt == 5'(PACKET_LEN - 1)) begin
                    cnt_d = '0;
                    if (pkts_q < 3'(MAX_PKTS) && |i_req) begin
                        advance = 1'b1;
                        pkts_d  = pkts_q + 3'd1;
                    end else begin
                        st_d = ST_TGUARD;
                    end
                end
            end
            ST_TGUARD: begin
                if (cur_cnt == 5'(GUARD_LEN - 1)) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end
            end
            default: begin
                st_d  = ST_IDLE;
                cnt_d = '0;
            end
        endcase
        sel_d = advance ? arb_idx : sel_q;
    end

    // Island states override the raster classification.
    always_comb begin
        case (cur_st)
            ST_DPRE:              per_s = PER_DPRE;
            ST_LGUARD, ST_TGUARD: per_s = PER_DGUARD;
            ST_DATA:              per_s = PER_DATA;
            default:              per_s = raster_per;
        endcase
    end

    // Scheduler state; reset aborts any island in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            pkts_q <= '0;
            sel_q  <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            pkts_q <= pkts_d;
            sel_q  <= sel_d;
        end
    end

    // First pipeline stage of the per-pixel result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_per_q <= PER_CTL;
            s1_gnt_q <= '0;
            s1_sel_q <= '0;
            s1_cnt_q <= '0;
        end else begin
            s1_per_q <= per_s;
            s1_gnt_q <= advance ? arb_gnt : '0;
            s1_sel_q <= sel_d;
            s1_cnt_q <= (cur_st == ST_DATA) ? cur_cnt : '0;
        end
    end

    // Output stage, aligned with the timing generator's sync/DE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_period  <= PER_CTL;
            o_gnt     <= '0;
            o_sel     <= '0;
            o_pkt_cnt <= '0;
        end else begin
            o_period  <= s1_per_q;
            o_gnt     <= s1_gnt_q;
            o_sel     <= s1_sel_q;
            o_pkt_cnt <= s1_cnt_q;
        end
    end

endmodule

// File: tb/tb_hvtx_sched.sv
// Scoreboard bench for hvtx_sched: two instances (MAX_PKTS 2 and 1) fed the
// same raster, each with its own requesters that drop once granted.
module tb_hvtx_sched;
    import hvtx_pkg::*;

    localparam int IS = 1284;
    localparam int FW = 1650;

    typedef struct {
        period_t    per;
        logic [1:0] gnt;
        logic [0:0] sel;
        logic [4:0] cnt;
        int         due;
        int         x;
        int         y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] px  = '0;
    logic [11:0] py  = '0;
    logic [1:0]  req   [2];
    period_t     per_o [2];
    logic [1:0]  gnt_o [2];
    logic [0:0]  sel_o [2];
    logic [4:0]  cnt_o [2];

    exp_t sbq [2][$];
    int   cyc   = 0;
    int   nchk  = 0;
    int   npass = 0;

    int         maxp [2] = '{2, 1};
    logic [1:0] pend [2];
    int         ptr  [2];
    logic [0:0] selh [2];
    logic [0:0] sel0 [2];
    int         npk  [2];
    int         gx   [2][4];
    int         gi   [2][4];
    logic       island [2];

    always #5 clk = ~clk;

    hvtx_sched #(.MAX_PKTS(2)) u0 (
        .i_clk(clk), .i_rst(rst), .i_x(px), .i_y(py), .i_req(req[0]),
        .o_period(per_o[0]), .o_gnt(gnt_o[0]), .o_sel(sel_o[0]), .o_pkt_cnt(cnt_o[0])
    );

    hvtx_sched #(.MAX_PKTS(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_x(px), .i_y(py), .i_req(req[1]),
        .o_period(per_o[1]), .o_gnt(gnt_o[1]), .o_sel(sel_o[1]), .o_pkt_cnt(cnt_o[1])
    );

    function automatic logic [1:0] onehot(int j);
        return (j == 0) ? 2'b01 : 2'b10;
    endfunction

    // 720p raster classification with no island.
    function automatic period_t raster(int x, int y);
        int yn;
        yn = (y == 749) ? 0 : y + 1;
        if (x < 1280 && y < 720) return PER_VIDEO;
        if (yn < 720 && x >= 1648) return PER_VGUARD;
        if (yn < 720 && x >= 1640) return PER_VPRE;
        return PER_CTL;
    endfunction

    // Decide the grants of one line from the pending mask at line start.
    task automatic plan_line(int i);
        logic [1:0] m;
        int j;
        m = pend[i];
        npk[i] = 0;
        island[i] = (pend[i] != 2'b00);
        for (int k = 0; k < maxp[i]; k++) begin
            if (m == 2'b00) break;
            j = ptr[i];
            if (!m[j[0]]) j = 1 - j;
            gx[i][k] = IS + 9 + 32 * k;
            gi[i][k] = j;
            m = m & ~onehot(j);
            ptr[i] = (j + 1) % 2;
            npk[i]++;
        end
    endtask

    function automatic exp_t exp_px(int i, int x, int y, int rst_at);
        exp_t e;
        int de;
        e.per = raster(x, y);
        e.gnt = '0;
        e.sel = sel0[i];
        e.cnt = '0;
        e.due = 0;
        e.x = x;
        e.y = y;
        if (rst_at >= 0 && x >= rst_at) begin
            e.sel = '0;
            return e;
        end
        if (island[i]) begin
            de = IS + 10 + 32 * npk[i];
            if (x >= IS && x < IS + 8) e.per = PER_DPRE;
            else if (x >= IS + 8 && x < IS + 10) e.per = PER_DGUARD;
            else if (x >= IS + 10 && x < de) begin
                e.per = PER_DATA;
                e.cnt = 5'((x - IS - 10) % 32);
            end else if (x >= de && x < de + 2) e.per = PER_DGUARD;
        end
        for (int k = 0; k < npk[i]; k++) begin
            if (gx[i][k] == x) e.gnt = onehot(gi[i][k]);
            if (gx[i][k] <= x) e.sel = 1'(gi[i][k]);
        end
        return e;
    endfunction

    task automatic push_exp(int i, int xx, int yy, int rst_at, logic in_rst);
        exp_t e;
        e = exp_px(i, xx, yy, rst_at);
        if (in_rst) begin
            e.per = PER_CTL;
            e.gnt = '0;
            e.sel = '0;
            e.cnt = '0;
            e.due = cyc + 1;
            if (sbq[i].size() > 0 && sbq[i][$].due == e.due) void'(sbq[i].pop_back());
        end else begin
            e.due = cyc + 2;
        end
        sbq[i].push_back(e);
    endtask

    task automatic run_line(int yy, logic [1:0] add, int rst_at);
        for (int i = 0; i < 2; i++) begin
            pend[i] = pend[i] | add;
            sel0[i] = selh[i];
            plan_line(i);
        end
        for (int xx = 0; xx < FW; xx++) begin
            @(negedge clk);
            px  = 12'(xx);
            py  = 12'(yy);
            rst = (rst_at >= 0 && xx >= rst_at && xx < rst_at + 2);
            for (int i = 0; i < 2; i++) begin
                req[i] = pend[i];
                for (int k = 0; k < npk[i]; k++)
                    if (gx[i][k] < xx && (rst_at < 0 || gx[i][k] < rst_at))
                        req[i] = req[i] & ~onehot(gi[i][k]);
                push_exp(i, xx, yy, rst_at, rst);
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < npk[i]; k++) begin
                if (rst_at < 0 || gx[i][k] < rst_at) begin
                    pend[i] = pend[i] & ~onehot(gi[i][k]);
                    selh[i] = 1'(gi[i][k]);
                end
            end
            if (rst_at >= 0) begin
                ptr[i]  = 0;
                selh[i] = '0;
            end
        end
    endtask

    // Monitor: compare every output cycle that has an expectation due.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < 2; i++) begin
                while (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
                    e = sbq[i].pop_front();
                    nchk++;
                    if (e.due == cyc && per_o[i] == e.per && gnt_o[i] == e.gnt &&
                        sel_o[i] == e.sel && cnt_o[i] == e.cnt) begin
                        npass++;
                    end else begin
                        $display("FAIL pixel u%0d x=%0d y=%0d: got per=%0d gnt=%b sel=%0d cnt=%0d, want per=%0d gnt=%b sel=%0d cnt=%0d (due %0d at %0d)",
                                 i, e.x, e.y, per_o[i], gnt_o[i], sel_o[i], cnt_o[i],
                                 e.per, e.gnt, e.sel, e.cnt, e.due, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i]    = '0;
            pend[i]   = '0;
            ptr[i]    = 0;
            selh[i]   = '0;
            sel0[i]   = '0;
            npk[i]    = 0;
            island[i] = 1'b0;
        end
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) push_exp(i, 0, 0, -1, 1'b1);
        end
        run_line(0,   2'b00, -1);   // raster only
        run_line(1,   2'b01, -1);   // single packet to requester 0
        run_line(2,   2'b10, -1);   // single packet to requester 1, pointer back to 0
        run_line(3,   2'b11, -1);   // both held: 01 then 10 on u0
        run_line(4,   2'b11, -1);   // u1 alternates one packet per line
        run_line(5,   2'b11, -1);
        run_line(719, 2'b00, -1);   // no video preamble before line 720
        run_line(749, 2'b00, -1);   // video preamble ahead of wrap to line 0
        run_line(6,   2'b11, 1300); // reset in the middle of the first packet
        run_line(7,   2'b11, -1);   // pointer restarted at requester 0
        repeat (4) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            nchk++;
            if (sbq[i].size() == 0) npass++;
            else $display("FAIL drain u%0d: got %0d expectations left, want 0", i, sbq[i].size());
        end
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
